alu_txn_monitor: RTL and testbench
==================================

// Module: alu_txn_monitor
// PURPOSE
//  Synthesizable, self-checking monitor for a pipelined, valid/ready ALU; passive, parametrised successor of the ALU checker.
//  Snoops request/response handshakes; golden model computes expected result/flags per request; queued in order, compared at response.
//  Sticky per-check error flags, saturating counters, first-error capture; sits beside the ALU in silicon, read by debug/CSR logic.
// PARAMETERS
//  WIDTH  32  operand/result width (>=8)
//  DEPTH  8   max outstanding requests tracked (power of 2, >=2)
//  CNT_W  16  width of txn/error counters
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous active-high reset
//  req_valid    in   1             ALU request valid (snooped)
//  req_ready    in   1             ALU request ready (snooped)
//  req_a        in   WIDTH         operand A
//  req_b        in   WIDTH         operand B
//  req_opcode   in   opcode_e      ADD,SUB,AND,OR,XOR,SLL,SRL,CMP
//  req_signed   in   1             signed operation
//  rsp_valid    in   1             ALU response valid (snooped)
//  rsp_ready    in   1             ALU response ready (snooped)
//  rsp_result   in   WIDTH         DUT result
//  rsp_flags    in   flags_t       DUT {zero,carry,overflow,negative}
//  clear        in   1             sync clear of flags/counters/capture (queue untouched)
//  err_flags    out  NCHK(7)       sticky error bits, indexed by chk_e
//  err_any      out  1             |err_flags
//  txn_count    out  CNT_W         compared responses, saturating
//  err_count    out  CNT_W         cycles with >=1 new error, saturating
//  first_code   out  chk_e         lowest-index check of first error
//  first_opcode out  opcode_e      opcode of first error (ADD if orphan/overflow)
//  first_txn    out  CNT_W         txn_count value at first error
//  level        out  $clog2(DEPTH)+1  outstanding entries
// BEHAVIOUR
//  push = req_valid&req_ready; pop = rsp_valid&rsp_ready; all outputs registered; rst -> every output 0, queue empty.
//  Golden model (at push): ADD a+b, carry=carry-out; SUB a-b, carry=borrow (a<b unsigned);
//   overflow only ADD/SUB with req_signed (sign rule); AND/OR/XOR bitwise, carry=ovf=0;
//   SLL/SRL by b (full value); b>=WIDTH -> 0; CMP -> {0..,a<b} signed/unsigned per req_signed;
//   zero=(result==0), negative=result[WIDTH-1]. Queue stores {opcode, exp_result, exp_flags}.
//  Checks at pop vs head: RESULT, ZERO, CARRY, OVERFLOW, NEGATIVE mismatch; ORPHAN = pop with queue empty;
//   QOVF = push with queue full and no pop (request dropped, not stored).
//  Latency: error visible on err_flags/err_count 1 cycle after offending handshake.
//  Simultaneous push+pop: pop compares old head; full+push+pop legal (no QOVF); empty+push+pop -> ORPHAN, push stored.
//  txn_count +1 per non-orphan pop; counters saturate at all-ones, no wrap.
//  first_* loaded only when err_flags==0 and new error occurs; held until clear/rst.
//  clear: flags/counters/first_* cleared, but errors/pops in the same cycle still recorded (clear-then-set).
//  rst mid-operation: queue flushed; responses to pre-reset requests then report ORPHAN.
// STRUCTURE
//  alu_pkg additions: chk_e {CHK_RESULT,CHK_ZERO,CHK_CARRY,CHK_OVF,CHK_NEG,CHK_ORPHAN,CHK_QOVF}, NCHK=7,
//   exp_entry_t struct, function alu_ref_model(a,b,opcode,signed) returning {result,flags}.
//  Sub-module alu_mon_fifo: sync FIFO (DEPTH, entry type), push/pop/full/empty/level, simultaneous push/pop when full.
// TESTING (WIDTH=32, DEPTH=8)
//  ADD signed 0x7FFFFFFF+1, DUT 0x80000000 {ovf=1,neg=1} -> err_flags=0, txn_count=1.
//  XOR 0xF0^0x0F, DUT 0xFF with carry=1 -> CHK_CARRY set next cycle, first_code=CARRY, first_opcode=XOR, err_count=1.
//  SLL a=1 b=32, DUT returns 1 {zero=0} -> CHK_RESULT and CHK_ZERO set, first_code=RESULT.
//  Response while queue empty -> CHK_ORPHAN, level stays 0, txn_count unchanged.
//  9 pushes, no pops -> CHK_QOVF on 9th, level=8; 8 matching responses -> no new errors, level=0.
//  clear same cycle as RESULT mismatch -> err_flags=RESULT only, err_count=1; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and golden model for the ALU transaction monitor.
// The reference model works on a fixed 64-bit datapath. The caller passes the
// real operand width, and the model masks everything to that width.
package alu_pkg;

   localparam int MAX_W = 64;
   localparam int NCHK  = 7;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_CMP = 3'd7
   } opcode_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic negative;
   } flags_t;

   typedef enum logic [2:0] {
      CHK_RESULT = 3'd0,
      CHK_ZERO   = 3'd1,
      CHK_CARRY  = 3'd2,
      CHK_OVF    = 3'd3,
      CHK_NEG    = 3'd4,
      CHK_ORPHAN = 3'd5,
      CHK_QOVF   = 3'd6
   } chk_e;

   typedef struct packed {
      logic [MAX_W-1:0] result;
      flags_t           flags;
   } alu_ref_t;

   // Expected result and flags for one request, evaluated at 'width' bits.
   function automatic alu_ref_t alu_ref_model(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input opcode_e          opcode,
                                              input logic             is_signed,
                                              input int               width);
      logic [MAX_W-1:0] mask_v;
      logic [MAX_W-1:0] sign_v;
      logic [MAX_W-1:0] am_v;
      logic [MAX_W-1:0] bm_v;
      logic [MAX_W-1:0] res_v;
      logic [MAX_W:0]   sum_v;
      logic             carry_v;
      logic             ovf_v;
      logic             lt_v;
      alu_ref_t         out_v;
      // A shift by the full width gives zero, so the subtraction wraps to all ones.
      mask_v  = (64'd1 << width) - 64'd1;
      sign_v  = 64'd1 << (width - 1);
      am_v    = a & mask_v;
      bm_v    = b & mask_v;
      sum_v   = 65'd0;
      res_v   = 64'd0;
      carry_v = 1'b0;
      ovf_v   = 1'b0;
      lt_v    = 1'b0;
      case (opcode)
         OP_ADD: begin
            sum_v   = {1'b0, am_v} + {1'b0, bm_v};
            res_v   = sum_v[MAX_W-1:0] & mask_v;
            carry_v = |(sum_v & ({1'b0, mask_v} + 65'd1));
            ovf_v   = is_signed & ~(|((am_v ^ bm_v) & sign_v)) & (|((res_v ^ am_v) & sign_v));
         end
         OP_SUB: begin
            res_v   = (am_v - bm_v) & mask_v;
            carry_v = (am_v < bm_v);
            ovf_v   = is_signed & (|((am_v ^ bm_v) & sign_v)) & (|((res_v ^ am_v) & sign_v));
         end
         OP_AND: res_v = am_v & bm_v;
         OP_OR:  res_v = am_v | bm_v;
         OP_XOR: res_v = am_v ^ bm_v;
         OP_SLL: res_v = (bm_v >= 64'(width)) ? 64'd0 : ((am_v << bm_v) & mask_v);
         OP_SRL: res_v = (bm_v >= 64'(width)) ? 64'd0 : (am_v >> bm_v);
         OP_CMP: begin
            // Flipping the sign bits turns a signed compare into an unsigned one.
            lt_v  = is_signed ? ((am_v ^ sign_v) < (bm_v ^ sign_v)) : (am_v < bm_v);
            res_v = {{(MAX_W-1){1'b0}}, lt_v};
         end
         default: res_v = 64'd0;
      endcase
      out_v.result         = res_v;
      out_v.flags.zero     = (res_v == 64'd0);
      out_v.flags.carry    = carry_v;
      out_v.flags.overflow = ovf_v;
      out_v.flags.negative = |(res_v & sign_v);
      return out_v;
   endfunction

endpackage

// File: rtl/alu_mon_fifo.sv
// Synchronous FIFO for expected ALU results. A push and a pop in the same
// cycle are accepted while the FIFO is full. The storage array has no reset.
module alu_mon_fifo #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ENTRY_W-1:0]       wr_data,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]      wr_ptr_r;
   logic [AW-1:0]      rd_ptr_r;
   logic [AW:0]        count_r;
   logic               wr_en_s;
   logic               rd_en_s;

   assign full    = (count_r == CNT_FULL);
   assign empty   = (count_r == {(AW+1){1'b0}});
   assign level   = count_r;
   assign rd_data = mem_r[rd_ptr_r];
   assign rd_en_s = pop & ~empty;
   assign wr_en_s = push & (~full | rd_en_s);

   // Store the entry being pushed.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Update the pointers and the occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/alu_txn_monitor.sv
// Passive monitor for a valid/ready ALU. It computes the expected response
// when each request is accepted and compares the oldest expectation with each
// response that is accepted. The error status is sticky and readable by debug logic.
module alu_txn_monitor
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     req_ready,
   input  logic [WIDTH-1:0]         req_a,
   input  logic [WIDTH-1:0]         req_b,
   input  opcode_e                  req_opcode,
   input  logic                     req_signed,
   input  logic                     rsp_valid,
   input  logic                     rsp_ready,
   input  logic [WIDTH-1:0]         rsp_result,
   input  flags_t                   rsp_flags,
   input  logic                     clear,
   output logic [NCHK-1:0]          err_flags,
   output logic                     err_any,
   output logic [CNT_W-1:0]         txn_count,
   output logic [CNT_W-1:0]         err_count,
   output chk_e                     first_code,
   output opcode_e                  first_opcode,
   output logic [CNT_W-1:0]         first_txn,
   output logic [$clog2(DEPTH):0]   level
);

   typedef struct packed {
      opcode_e          opcode;
      logic [WIDTH-1:0] result;
      flags_t           flags;
   } exp_entry_t;

   localparam int               ENTRY_W = $bits(exp_entry_t);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Trim the 64-bit golden result to the monitored width.
   function automatic exp_entry_t build_entry(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input opcode_e          op,
                                              input logic             sgn);
      alu_ref_t   ref_v;
      exp_entry_t ent_v;
      ref_v        = alu_ref_model(MAX_W'(a), MAX_W'(b), op, sgn, WIDTH);
      ent_v.opcode = op;
      ent_v.result = ref_v.result[WIDTH-1:0];
      ent_v.flags  = ref_v.flags;
      return ent_v;
   endfunction

   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic             fifo_pop_s;
   exp_entry_t       wr_entry_s;
   exp_entry_t       head_s;
   logic [NCHK-1:0]  new_err_s;
   logic [NCHK-1:0]  flags_base_s;
   logic [NCHK-1:0]  flags_next_s;
   logic [CNT_W-1:0] txn_base_s;
   logic [CNT_W-1:0] txn_next_s;
   logic [CNT_W-1:0] ecnt_base_s;
   logic [CNT_W-1:0] ecnt_next_s;
   logic             load_first_s;
   chk_e             first_code_s;
   opcode_e          first_op_s;

   assign push_s     = req_valid & req_ready;
   assign pop_s      = rsp_valid & rsp_ready;
   assign fifo_pop_s = pop_s & ~empty_s;
   assign wr_entry_s = build_entry(req_a, req_b, req_opcode, req_signed);

   alu_mon_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (wr_entry_s),
      .rd_data (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .level   (level)
   );

   // Find this cycle's new errors. Field checks use the head entry only when a pop matches it.
   always_comb begin
      new_err_s = {NCHK{1'b0}};
      if (fifo_pop_s) begin
         new_err_s[CHK_RESULT] = (rsp_result != head_s.result);
         new_err_s[CHK_ZERO]   = (rsp_flags.zero != head_s.flags.zero);
         new_err_s[CHK_CARRY]  = (rsp_flags.carry != head_s.flags.carry);
         new_err_s[CHK_OVF]    = (rsp_flags.overflow != head_s.flags.overflow);
         new_err_s[CHK_NEG]    = (rsp_flags.negative != head_s.flags.negative);
      end else begin
         new_err_s[CHK_RESULT] = 1'b0;
      end
      new_err_s[CHK_ORPHAN] = pop_s & empty_s;
      new_err_s[CHK_QOVF]   = push_s & full_s & ~pop_s;
   end

   // Pick the lowest-index new error and the opcode that goes with it.
   always_comb begin
      first_code_s = CHK_RESULT;
      for (int i = NCHK - 1; i >= 0; i--) begin
         first_code_s = new_err_s[i] ? chk_e'(3'(i)) : first_code_s;
      end
      first_op_s = (|new_err_s[4:0]) ? head_s.opcode : OP_ADD;
   end

   // Apply clear first, then add this cycle's events. Counters saturate.
   always_comb begin
      flags_base_s = clear ? {NCHK{1'b0}} : err_flags;
      txn_base_s   = clear ? {CNT_W{1'b0}} : txn_count;
      ecnt_base_s  = clear ? {CNT_W{1'b0}} : err_count;
      flags_next_s = flags_base_s | new_err_s;
      txn_next_s   = (fifo_pop_s && (txn_base_s != CNT_MAX)) ? (txn_base_s + CNT_ONE) : txn_base_s;
      ecnt_next_s  = ((|new_err_s) && (ecnt_base_s != CNT_MAX)) ? (ecnt_base_s + CNT_ONE) : ecnt_base_s;
      load_first_s = (|new_err_s) & (flags_base_s == {NCHK{1'b0}});
   end

   // Register the status outputs. The first_* fields load only on the first error since the last clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_flags    <= {NCHK{1'b0}};
         err_any      <= 1'b0;
         txn_count    <= {CNT_W{1'b0}};
         err_count    <= {CNT_W{1'b0}};
         first_code   <= CHK_RESULT;
         first_opcode <= OP_ADD;
         first_txn    <= {CNT_W{1'b0}};
      end else begin
         err_flags <= flags_next_s;
         err_any   <= |flags_next_s;
         txn_count <= txn_next_s;
         err_count <= ecnt_next_s;
         if (load_first_s) begin
            first_code   <= first_code_s;
            first_opcode <= first_op_s;
            first_txn    <= txn_base_s;
         end else if (clear) begin
            first_code   <= CHK_RESULT;
            first_opcode <= OP_ADD;
            first_txn    <= {CNT_W{1'b0}};
         end else begin
            first_code   <= first_code;
            first_opcode <= first_opcode;
            first_txn    <= first_txn;
         end
      end
   end

endmodule

// File: tb/tb_alu_txn_monitor.sv
// Directed testbench for alu_txn_monitor (WIDTH=32, DEPTH=8). Expected values are worked out by hand.
module tb_alu_txn_monitor;
   import alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_valid;
   logic                   req_ready;
   logic [WIDTH-1:0]       req_a;
   logic [WIDTH-1:0]       req_b;
   opcode_e                req_opcode;
   logic                   req_signed;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [WIDTH-1:0]       rsp_result;
   flags_t                 rsp_flags;
   logic                   clear;
   logic [NCHK-1:0]        err_flags;
   logic                   err_any;
   logic [CNT_W-1:0]       txn_count;
   logic [CNT_W-1:0]       err_count;
   chk_e                   first_code;
   opcode_e                first_opcode;
   logic [CNT_W-1:0]       first_txn;
   logic [$clog2(DEPTH):0] level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_txn_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .req_opcode(req_opcode), .req_signed(req_signed),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .clear(clear), .err_flags(err_flags), .err_any(err_any), .txn_count(txn_count),
      .err_count(err_count), .first_code(first_code), .first_opcode(first_opcode),
      .first_txn(first_txn), .level(level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input opcode_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
      req_valid = 1'b1; req_ready = 1'b1; req_opcode = op; req_a = a; req_b = b; req_signed = sgn;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic rsp(input logic [WIDTH-1:0] res, input logic [3:0] flg);
      rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_result = res; rsp_flags = flags_t'(flg);
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_flags"}, 64'(err_flags), 64'd0);
      chk({tag, "_any"},   64'(err_any),   64'd0);
      chk({tag, "_txn"},   64'(txn_count), 64'd0);
      chk({tag, "_ecnt"},  64'(err_count), 64'd0);
      chk({tag, "_level"}, 64'(level),     64'd0);
      chk({tag, "_fcode"}, 64'(first_code), 64'd0);
      chk({tag, "_fop"},   64'(first_opcode), 64'd0);
      chk({tag, "_ftxn"},  64'(first_txn), 64'd0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0;
      req_valid = 1'b0; req_ready = 1'b0; req_a = 32'd0; req_b = 32'd0;
      req_opcode = OP_ADD; req_signed = 1'b0;
      rsp_valid = 1'b0; rsp_ready = 1'b0; rsp_result = 32'd0; rsp_flags = flags_t'(4'b0000);
      tick(); tick();
      rst = 1'b0;
      check_all_zero("reset");

      // Signed ADD overflow, answered correctly.
      req(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      chk("add_level", 64'(level), 64'd1);
      rsp(32'h8000_0000, 4'b0011);
      chk("add_flags", 64'(err_flags), 64'd0);
      chk("add_txn",   64'(txn_count), 64'd1);
      chk("add_level0", 64'(level), 64'd0);

      // XOR answered with a stray carry.
      req(OP_XOR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
      rsp(32'h0000_00FF, 4'b0100);
      chk("xor_flags", 64'(err_flags), 64'b0000100);
      chk("xor_any",   64'(err_any), 64'd1);
      chk("xor_fcode", 64'(first_code), 64'(CHK_CARRY));
      chk("xor_fop",   64'(first_opcode), 64'(OP_XOR));
      chk("xor_ecnt",  64'(err_count), 64'd1);
      chk("xor_txn",   64'(txn_count), 64'd2);

      // A clear on its own.
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr_flags", 64'(err_flags), 64'd0);
      chk("clr_ecnt",  64'(err_count), 64'd0);
      chk("clr_txn",   64'(txn_count), 64'd0);

      // SLL by the full width should give 0; the DUT returns 1.
      req(OP_SLL, 32'h0000_0001, 32'd32, 1'b0);
      rsp(32'h0000_0001, 4'b0000);
      chk("sll_flags", 64'(err_flags), 64'b0000011);
      chk("sll_fcode", 64'(first_code), 64'(CHK_RESULT));
      chk("sll_fop",   64'(first_opcode), 64'(OP_SLL));
      chk("sll_ecnt",  64'(err_count), 64'd1);
      chk("sll_txn",   64'(txn_count), 64'd1);

      // Orphan response.
      rsp(32'h0000_0005, 4'b0000);
      chk("orph_flags", 64'(err_flags), 64'b0100011);
      chk("orph_level", 64'(level), 64'd0);
      chk("orph_txn",   64'(txn_count), 64'd1);
      chk("orph_ecnt",  64'(err_count), 64'd2);
      chk("orph_fcode", 64'(first_code), 64'(CHK_RESULT));

      // Fill the queue, then overflow it.
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 1; i <= 8; i++) req(OP_ADD, 32'(i), 32'd1, 1'b0);
      chk("fill_level", 64'(level), 64'd8);
      chk("fill_flags", 64'(err_flags), 64'd0);
      req(OP_ADD, 32'd9, 32'd1, 1'b0);
      chk("qovf_flags", 64'(err_flags), 64'b1000000);
      chk("qovf_level", 64'(level), 64'd8);
      chk("qovf_fcode", 64'(first_code), 64'(CHK_QOVF));
      chk("qovf_fop",   64'(first_opcode), 64'(OP_ADD));
      chk("qovf_ecnt",  64'(err_count), 64'd1);
      for (int i = 1; i <= 8; i++) rsp(32'(i + 1), 4'b0000);
      chk("drain_flags", 64'(err_flags), 64'b1000000);
      chk("drain_ecnt",  64'(err_count), 64'd1);
      chk("drain_txn",   64'(txn_count), 64'd8);
      chk("drain_level", 64'(level), 64'd0);

      // A RESULT mismatch in the same cycle as a clear.
      req(OP_AND, 32'h0000_00FF, 32'h0000_000F, 1'b0);
      clear = 1'b1;
      rsp(32'h0000_000E, 4'b0000);
      clear = 1'b0;
      chk("clrset_flags", 64'(err_flags), 64'b0000001);
      chk("clrset_ecnt",  64'(err_count), 64'd1);
      chk("clrset_txn",   64'(txn_count), 64'd1);
      chk("clrset_fop",   64'(first_opcode), 64'(OP_AND));

      // Push and pop together with the queue empty: ORPHAN, and the push is kept.
      req_valid = 1'b1; req_ready = 1'b1; req_opcode = OP_SUB; req_a = 32'd5; req_b = 32'd3; req_signed = 1'b0;
      rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_result = 32'd0; rsp_flags = flags_t'(4'b0000);
      tick();
      req_valid = 1'b0; rsp_valid = 1'b0;
      chk("pp_flags", 64'(err_flags), 64'b0100001);
      chk("pp_level", 64'(level), 64'd1);
      chk("pp_txn",   64'(txn_count), 64'd1);
      chk("pp_ecnt",  64'(err_count), 64'd2);
      rsp(32'd2, 4'b0000);
      chk("pp2_txn",   64'(txn_count), 64'd2);
      chk("pp2_level", 64'(level), 64'd0);

      // Borrow, signed compare, SRL and a zero result, all answered correctly.
      req(OP_SUB, 32'd3, 32'd5, 1'b0);
      req(OP_CMP, 32'hFFFF_FFFF, 32'd1, 1'b1);
      req(OP_SRL, 32'h0000_0080, 32'd4, 1'b0);
      req(OP_OR,  32'd0, 32'd0, 1'b0);
      rsp(32'hFFFF_FFFE, 4'b0101);
      rsp(32'd1, 4'b0000);
      rsp(32'd8, 4'b0000);
      rsp(32'd0, 4'b1000);
      chk("mix_flags", 64'(err_flags), 64'b0100001);
      chk("mix_ecnt",  64'(err_count), 64'd2);
      chk("mix_txn",   64'(txn_count), 64'd6);

      // Push and pop together with the queue full are legal; this also wraps the pointers.
      for (int i = 1; i <= 8; i++) req(OP_ADD, 32'(i), 32'd0, 1'b0);
      req_valid = 1'b1; req_ready = 1'b1; req_opcode = OP_ADD; req_a = 32'd100; req_b = 32'd0; req_signed = 1'b0;
      rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_result = 32'd1; rsp_flags = flags_t'(4'b0000);
      tick();
      req_valid = 1'b0; rsp_valid = 1'b0;
      chk("fpp_flags", 64'(err_flags), 64'b0100001);
      chk("fpp_level", 64'(level), 64'd8);
      for (int i = 2; i <= 8; i++) rsp(32'(i), 4'b0000);
      rsp(32'd100, 4'b0000);
      chk("fpp_dflags", 64'(err_flags), 64'b0100001);
      chk("fpp_ecnt",   64'(err_count), 64'd2);
      chk("fpp_txn",    64'(txn_count), 64'd15);
      chk("fpp_dlevel", 64'(level), 64'd0);

      // Reset with requests outstanding, then a late response.
      req(OP_ADD, 32'd1, 32'd1, 1'b0);
      req(OP_ADD, 32'd2, 32'd2, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      check_all_zero("midrst");
      rsp(32'd2, 4'b0000);
      chk("late_flags", 64'(err_flags), 64'b0100000);
      chk("late_fcode", 64'(first_code), 64'(CHK_ORPHAN));
      chk("late_txn",   64'(txn_count), 64'd0);
      chk("late_level", 64'(level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
